// File: rtl/blink_pkg.sv
// Shared definitions for the blink generator / monitor pair.
//   state_e           : monitor FSM states
//   BLINK_HALF_PERIOD : nominal clocks between toggles, common to both ends
//   tol_lower()       : lower tolerance bound, clamped at zero
package blink_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        LOCKED
    } state_e;

    localparam int unsigned BLINK_HALF_PERIOD = 25000;

    function automatic int unsigned tol_lower(input int unsigned half_period,
                                              input int unsigned tol);
        return (tol > half_period) ? 0 : half_period - tol;
    endfunction

endpackage

// File: rtl/blink_monitor_if.sv
// Bundle between the toggle source and the blink monitor.
//   B_in         : toggle bit under test (source -> monitor)
//   half_period  : last measured edge-to-edge clock count
//   period_valid : one-cycle pulse when half_period updates
//   locked       : signal matches the expected half-period
//   stall        : no edge seen within the allowed window
// master = source / observer side, slave = monitor side.
interface blink_monitor_if #(
    parameter int unsigned CNT_W = 16
);
    logic             B_in;
    logic [CNT_W-1:0] half_period;
    logic             period_valid;
    logic             locked;
    logic             stall;

    modport master (
        output B_in,
        input  half_period,
        input  period_valid,
        input  locked,
        input  stall
    );

    modport slave (
        input  B_in,
        output half_period,
        output period_valid,
        output locked,
        output stall
    );
endinterface

// File: rtl/sync_edge.sv
// Two-flop synchroniser followed by a delay flop; flags any change of the
// synchronised bit.
//   clk, rst : clock, asynchronous active-high reset
//   i_async  : bit asynchronous to clk
//   o_sync   : synchronised level
//   o_edge   : high for one cycle after either a rising or falling edge
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_edge
);
    logic r_meta;
    logic r_sync;
    logic r_dly;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_dly  <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_dly  <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_edge = r_sync ^ r_dly;
endmodule

// File: rtl/blink_monitor.sv
// Receive-side checker for a periodic toggle bit. Measures the clock count
// between successive edges, declares lock after LOCK_COUNT consecutive
// in-tolerance half-periods and flags a stall when the bit stops toggling.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of blink_monitor_if (B_in in; half_period,
//              period_valid, locked, stall out)
module blink_monitor
    import blink_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = BLINK_HALF_PERIOD,
    parameter int unsigned TOL         = 16,
    parameter int unsigned LOCK_COUNT  = 4,
    parameter int unsigned CNT_W       = 16
) (
    input logic            clk,
    input logic            rst,
    blink_monitor_if.slave bus
);
    localparam logic [CNT_W-1:0] Limit   = CNT_W'(HALF_PERIOD + TOL + 1);
    // Bounds carry one extra bit so HALF_PERIOD+TOL never wraps.
    localparam logic [CNT_W:0]   TolLo   = (CNT_W + 1)'(tol_lower(HALF_PERIOD, TOL));
    localparam logic [CNT_W:0]   TolHi   = (CNT_W + 1)'(HALF_PERIOD + TOL);
    localparam logic [3:0]       LockMax = 4'(LOCK_COUNT);

    logic w_edge;
    logic w_sync_unused;

    state_e           r_state,        w_state_nxt;
    logic [CNT_W-1:0] r_cnt,          w_cnt_nxt;
    logic [3:0]       r_match,        w_match_nxt;
    logic [CNT_W-1:0] r_half_period,  w_half_period_nxt;
    logic             r_period_valid, w_period_valid_nxt;
    logic             r_locked,       w_locked_nxt;
    logic             r_stall,        w_stall_nxt;

    logic       w_in_tol;
    logic       w_cnt_will_hit;
    logic [3:0] w_match_inc;

    sync_edge u_sync_edge (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.B_in),
        .o_sync  (w_sync_unused),
        .o_edge  (w_edge)
    );

    assign w_in_tol       = ({1'b0, r_cnt} >= TolLo) && ({1'b0, r_cnt} <= TolHi);
    // Counter would reach Limit on this clock; an edge in the same cycle wins.
    assign w_cnt_will_hit = (r_cnt >= Limit - CNT_W'(1));
    assign w_match_inc    = (r_match < LockMax) ? 4'(r_match + 4'd1) : LockMax;

    always_comb begin
        w_state_nxt        = r_state;
        w_match_nxt        = r_match;
        w_half_period_nxt  = r_half_period;
        w_period_valid_nxt = 1'b0;
        w_locked_nxt       = r_locked;
        w_stall_nxt        = r_stall;

        if (w_edge) begin
            w_cnt_nxt = CNT_W'(1);
        end else if (r_cnt < Limit) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
            w_cnt_nxt = Limit;
        end

        unique case (r_state)
            IDLE: begin
                // First edge only starts the count; nothing to measure yet.
                if (w_edge) begin
                    w_state_nxt = MEASURE;
                    w_stall_nxt = 1'b0;
                end
            end
            MEASURE, LOCKED: begin
                if (w_edge) begin
                    w_half_period_nxt  = r_cnt;
                    w_period_valid_nxt = 1'b1;
                    if (w_in_tol) begin
                        w_match_nxt = w_match_inc;
                        if (w_match_inc == LockMax) begin
                            w_state_nxt  = LOCKED;
                            w_locked_nxt = 1'b1;
                        end else begin
                            w_state_nxt = MEASURE;
                        end
                    end else begin
                        w_match_nxt  = 4'd0;
                        w_locked_nxt = 1'b0;
                        w_state_nxt  = MEASURE;
                    end
                end else if (w_cnt_will_hit) begin
                    w_stall_nxt  = 1'b1;
                    w_locked_nxt = 1'b0;
                    w_match_nxt  = 4'd0;
                    w_state_nxt  = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_match        <= 4'd0;
            r_half_period  <= '0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_stall        <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_match        <= w_match_nxt;
            r_half_period  <= w_half_period_nxt;
            r_period_valid <= w_period_valid_nxt;
            r_locked       <= w_locked_nxt;
            r_stall        <= w_stall_nxt;
        end
    end

    assign bus.half_period  = r_half_period;
    assign bus.period_valid = r_period_valid;
    assign bus.locked       = r_locked;
    assign bus.stall        = r_stall;
endmodule

// File: tb/tb_blink_monitor.sv
// Bench for blink_monitor: planned toggle gaps are turned into an expected
// event stream (measurement / stall rise / stall fall) from the timing rules,
// then driven; a monitor pops and compares whenever the DUT shows an event.
module tb_blink_monitor;
    localparam int HP = 10;
    localparam int TL = 1;
    localparam int LC = 4;
    localparam int CW = 8;

    localparam int EvMeas    = 0;
    localparam int EvStall   = 1;
    localparam int EvUnstall = 2;

    typedef struct {
        int kind;
        int hp;
        int lk;
    } ev_t;

    logic clk;
    logic rst;

    blink_monitor_if #(.CNT_W(CW)) bus ();

    blink_monitor #(
        .HALF_PERIOD (HP),
        .TOL         (TL),
        .LOCK_COUNT  (LC),
        .CNT_W       (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  n_tests;
    int  n_fail;
    ev_t exp_q[$];
    int  plan[$];

    // Reference model state: a run is active once a first edge has been seen.
    bit m_active;
    bit m_stalled;
    int m_match;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void push_ev(input int kind, input int hp, input int lk);
        ev_t e;
        e.kind = kind;
        e.hp   = hp;
        e.lk   = lk;
        exp_q.push_back(e);
    endfunction

    // Every toggle becomes an edge with a fixed latency, so edge spacing equals
    // the planned gap. Gaps up to HP+TL are measured; longer ones time out
    // first (stall), and the late toggle only restarts the run.
    task automatic model_plan(input bit trailing_idle);
        foreach (plan[i]) begin
            int g;
            g = plan[i];
            if (!m_active) begin
                if (m_stalled) push_ev(EvUnstall, 0, 0);
                m_active  = 1'b1;
                m_stalled = 1'b0;
                m_match   = 0;
            end else if (g <= HP + TL) begin
                if (g >= HP - TL) m_match = (m_match < LC) ? m_match + 1 : LC;
                else              m_match = 0;
                push_ev(EvMeas, g, (m_match == LC) ? 1 : 0);
            end else begin
                push_ev(EvStall, 0, 0);
                push_ev(EvUnstall, 0, 0);
                m_match = 0;
            end
        end
        if (trailing_idle && m_active) begin
            push_ev(EvStall, 0, 0);
            m_active  = 1'b0;
            m_stalled = 1'b1;
            m_match   = 0;
        end
    endtask

    task automatic drive_plan(input bit trailing_idle);
        foreach (plan[i]) begin
            repeat (plan[i]) @(negedge clk);
            bus.B_in = ~bus.B_in;
        end
        if (trailing_idle) repeat (2 * (HP + TL) + 6) @(negedge clk);
        else               repeat (5) @(negedge clk);
    endtask

    task automatic run_plan(input bit trailing_idle);
        model_plan(trailing_idle);
        drive_plan(trailing_idle);
    endtask

    task automatic random_plan(input int n);
        plan.delete();
        for (int i = 0; i < n; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2, 3: plan.push_back(HP);
                4:          plan.push_back(HP - TL);
                5:          plan.push_back(HP + TL);
                6:          plan.push_back(HP - TL - 1);
                7:          plan.push_back(HP + TL + 1);
                8:          plan.push_back(int'($urandom_range(2, 7)));
                default:    plan.push_back(int'($urandom_range(13, 16)));
            endcase
        end
    endtask

    // Asynchronous reset mid-run: outputs must clear without waiting for a clock.
    task automatic mid_reset();
        @(negedge clk);
        #2;
        rst      = 1'b1;
        bus.B_in = 1'b0;
        #1;
        chk("rst_half_period", int'(bus.half_period), 0);
        chk("rst_period_valid", int'(bus.period_valid), 0);
        chk("rst_locked", int'(bus.locked), 0);
        chk("rst_stall", int'(bus.stall), 0);
        chk("rst_pending_events", exp_q.size(), 0);
        exp_q.delete();
        m_active  = 1'b0;
        m_stalled = 1'b0;
        m_match   = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        m_active  = 1'b0;
        m_stalled = 1'b0;
        m_match   = 0;
        rst       = 1'b1;
        bus.B_in  = 1'b0;

        fork
            begin : monitor
                bit  prev_stall;
                ev_t e;
                prev_stall = 1'b0;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        prev_stall = 1'b0;
                    end else begin
                        if (bus.period_valid) begin
                            if (exp_q.size() == 0) begin
                                chk("unexpected_period_valid", 1, 0);
                            end else begin
                                e = exp_q.pop_front();
                                chk("event_kind_meas", EvMeas, e.kind);
                                chk("half_period", int'(bus.half_period), e.hp);
                                chk("locked_at_meas", int'(bus.locked), e.lk);
                                chk("stall_at_meas", int'(bus.stall), 0);
                            end
                        end
                        if (bus.stall && !prev_stall) begin
                            if (exp_q.size() == 0) begin
                                chk("unexpected_stall_rise", 1, 0);
                            end else begin
                                e = exp_q.pop_front();
                                chk("event_kind_stall", EvStall, e.kind);
                                chk("locked_at_stall", int'(bus.locked), 0);
                            end
                        end
                        if (!bus.stall && prev_stall) begin
                            if (exp_q.size() == 0) begin
                                chk("unexpected_stall_fall", 1, 0);
                            end else begin
                                e = exp_q.pop_front();
                                chk("event_kind_unstall", EvUnstall, e.kind);
                                chk("pv_at_unstall", int'(bus.period_valid), 0);
                            end
                        end
                        prev_stall = bus.stall;
                    end
                end
            end
        join_none

        #1;
        chk("init_half_period", int'(bus.half_period), 0);
        chk("init_period_valid", int'(bus.period_valid), 0);
        chk("init_locked", int'(bus.locked), 0);
        chk("init_stall", int'(bus.stall), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Steady 10-clock toggles: lock on the 4th measurement, then reset mid-run.
        plan = {3, 10, 10, 10, 10, 10};
        run_plan(1'b0);
        chk("locked_before_reset", int'(bus.locked), 1);
        mid_reset();

        // Lock, over-long gap (stall), relock; exact-bound gaps 11 and 9.
        plan = {4, 10, 10, 10, 10, 10, 13, 10, 10, 10, 10, 10, 11, 9};
        run_plan(1'b1);

        // Tolerance edges accepted, one clock beyond rejected (8 low, 12 stalls).
        plan = {5, 9, 11, 9, 11, 8, 10, 10, 10, 10, 12, 10, 11, 9, 11, 9};
        run_plan(1'b1);

        for (int p = 0; p < 4; p++) begin
            random_plan(40);
            if (p == 2) begin
                run_plan(1'b0);
                mid_reset();
            end else begin
                run_plan(1'b1);
            end
        end

        repeat (10) @(negedge clk);
        chk("events_left_over", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
